mc_alu: RTL
===========

// Module: mc_alu
// PURPOSE
//  Multi-cycle, parametrised ALU for the next-generation CPU datapath; replaces the combinational ALU.
//  Takes one operation per valid/ready handshake. Simple ops finish in one cycle; shift and multiply are iterative.
//  Holds result and flags (zero/carry/negative) in registers until the consumer accepts them.
//  Sits between register-file read and writeback, which stall on in_ready/out_valid.
// PARAMETERS
//  WIDTH    8                  datapath width in bits (>=4)
//  SHAMT_W  $clog2(WIDTH)      shift-amount field width
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      op/operands valid
//  in_ready   out  1      ALU can accept an op
//  op         in   4      operation code (alu_pkg::op_e)
//  input1     in   WIDTH  operand A
//  input2     in   WIDTH  operand B / shift control
//  out_valid  out  1      result and flags valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  zero       out  1      result == 0
//  carry      out  1      carry/borrow/shift-out/overflow, per op
//  negative   out  1      result[WIDTH-1]
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; result=0; zero=carry=negative=0; iter counter=0.
//  FSM IDLE -> EXEC -> DONE -> IDLE. in_ready=1 only in IDLE. Accept = in_valid & in_ready; operands latch on accept.
//  IDLE:
//   - Accept of a single-cycle op, or a SHIFT with amount 0: go to DONE; out_valid=1 on the next cycle.
//   - Accept of a SHIFT with amount>0, or MUL: go to EXEC.
//  EXEC: one iteration per cycle; go to DONE when the counter expires.
//  DONE: out_valid=1; result and flags held stable. out_valid & out_ready -> IDLE (in_ready=1 on the next cycle).
//  Ops (inputs unsigned unless noted; carry=0 where not stated):
//   0 XOR: A^B
//   1 CMP: 0 if A==B, else 1
//   2 ADD: A+B mod 2^WIDTH; carry=carry-out
//   3 AND: A&B
//   4 SHIFT (logical): amount=B[SHAMT_W-1:0]; B[SHAMT_W]=1 shifts left, 0 shifts right.
//     1 bit/cycle; latency 1+amount; carry=last bit shifted out (0 if amount=0).
//   5 PASS: A
//   6 SUB: A-B mod 2^WIDTH; carry=1 iff A<B (borrow)
//   7 OR: A|B
//   8 MUL: see CONFIGURATION
//   9..15 illegal: result all ones, carry=0, 1-cycle latency
//  Flags: zero and negative are computed from the final result and registered with it.
//  in_valid while busy: ignored. Operands are not re-sampled mid-operation.
//  Reset asserted mid-EXEC: operation is abandoned and no out_valid is produced.
// CONFIGURATION
//  MC_ALU_MUL_EN defined:
//   - op 8 = shift-add multiply, WIDTH iterations, latency WIDTH+1.
//   - result=low WIDTH bits of A*B; carry=1 iff high WIDTH bits != 0.
//  MC_ALU_MUL_EN undefined:
//   - op 8 is illegal (all ones, 1-cycle latency); no multiplier hardware or high-half register.
// STRUCTURE
//  Package alu_pkg:
//   - op_e (4-bit enum, codes above)
//   - state_e {IDLE, EXEC, DONE}
//   - localparam ALL_ONES helper
//  Sub-module mc_alu_iter:
//   - owns the iteration counter, shift register and (if MC_ALU_MUL_EN) the accumulator
//   - interface: start/done/result/carry
//  Top: FSM, single-cycle op mux, flag registers.
// TESTING (WIDTH=8)
//  1. ADD A=0xF0 B=0x20, out_ready=1 -> result=0x10, carry=1, zero=0, negative=0; out_valid 1 cycle after accept.
//  2. CMP A=0x5A B=0x5A -> result=0x00, zero=1. SUB A=0x03 B=0x05 -> result=0xFE, carry=1, negative=1.
//  3. SHIFT A=0x81 B=0x0B (left 3) -> result=0x08, carry=0; out_valid exactly 4 cycles after accept; in_ready=0 meanwhile.
//     SHIFT A=0x81 B=0x01 (right 1) -> result=0x40, carry=1.
//  4. Backpressure: ADD completes, out_ready=0 for 5 cycles; in_valid=1 with new operands throughout
//     -> result/flags stable, in_ready=0, new op accepted only the cycle after out_ready=1.
//  5. rst_n low 2 cycles mid-SHIFT (B=0x0F) -> all outputs at reset values immediately; in_ready=1 after release;
//     no stray out_valid.
//  6. MUL A=0x10 B=0x20: with MC_ALU_MUL_EN -> result=0x00, zero=1, carry=1, latency 9;
//     without it -> result=0xFF, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and the all-ones constant.
// The MC_ALU_MUL_EN build option only changes how mc_alu decodes OP_MUL.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_XOR   = 4'd0,
        OP_CMP   = 4'd1,
        OP_ADD   = 4'd2,
        OP_AND   = 4'd3,
        OP_SHIFT = 4'd4,
        OP_PASS  = 4'd5,
        OP_SUB   = 4'd6,
        OP_OR    = 4'd7,
        OP_MUL   = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest datapath supported; users slice ALL_ONES down to their WIDTH.
    localparam int MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/mc_alu_iter.sv
// Iterative engine: 1-bit-per-cycle logical shifter and, with MC_ALU_MUL_EN, a shift-add multiplier.
// o_result/o_carry show the value produced by the final iteration while o_done is high.
module mc_alu_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_left,
    input  logic [CNT_W-1:0] i_count,
    input  logic [WIDTH-1:0] i_a,
`ifdef MC_ALU_MUL_EN
    input  logic             i_mul,
    input  logic [WIDTH-1:0] i_b,
`endif
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    logic             r_busy;
    logic             r_left;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nx;
    logic             w_carry_nx;
`ifdef MC_ALU_MUL_EN
    logic             r_mul;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH:0]   w_sum;
`endif

    always_comb begin
        w_shreg_nx = r_left ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
        w_carry_nx = r_left ? r_shreg[WIDTH-1] : r_shreg[0];
`ifdef MC_ALU_MUL_EN
        // {r_acc, r_shreg} is the product register; multiplier bits leave from the bottom.
        w_sum    = {1'b0, r_acc} + (r_shreg[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_acc_nx = r_acc;
        if (r_mul) begin
            w_acc_nx   = w_sum[WIDTH:1];
            w_shreg_nx = {w_sum[0], r_shreg[WIDTH-1:1]};
            w_carry_nx = |w_sum[WIDTH:1];
        end
`endif
    end

    assign o_done   = r_busy && (r_cnt == CNT_W'(1));
    assign o_result = w_shreg_nx;
    assign o_carry  = w_carry_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_left  <= 1'b0;
            r_cnt   <= '0;
            r_shreg <= '0;
`ifdef MC_ALU_MUL_EN
            r_mul   <= 1'b0;
            r_mcand <= '0;
            r_acc   <= '0;
`endif
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_left  <= i_left;
            r_cnt   <= i_count;
            r_shreg <= i_a;
`ifdef MC_ALU_MUL_EN
            r_mul   <= i_mul;
            r_mcand <= i_a;
            r_acc   <= '0;
            if (i_mul) begin
                r_shreg <= i_b;
            end
`endif
        end else if (r_busy) begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_shreg <= w_shreg_nx;
`ifdef MC_ALU_MUL_EN
            r_acc   <= w_acc_nx;
`endif
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU with valid/ready on both sides; result and flags are held until consumed.
// Define MC_ALU_MUL_EN to enable the iterative multiplier on OP_MUL (otherwise OP_MUL is illegal).
module mc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends combinationally on valid, and the producer holds data while valid&!ready.

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_ONES = ALL_ONES[WIDTH-1:0];

    state_e             r_state;
    state_e             w_state_nx;
    logic               w_accept;
    logic               w_iter_op;
    logic               w_is_mul;
    logic               w_iter_start;
    logic               w_iter_done;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_shift_left;
    logic [CNT_W-1:0]   w_iter_cnt;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_simple_res;
    logic               w_simple_carry;
    logic [WIDTH-1:0]   w_iter_res;
    logic               w_iter_carry;
    logic               w_load;
    logic [WIDTH-1:0]   w_load_res;
    logic               w_load_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_negative;

    assign w_accept     = in_valid & in_ready;
    assign w_shamt      = input2[SHAMT_W-1:0];
    assign w_shift_left = input2[SHAMT_W];
    assign w_add        = {1'b0, input1} + {1'b0, input2};
    assign w_sub        = {1'b0, input1} - {1'b0, input2};

`ifdef MC_ALU_MUL_EN
    assign w_is_mul = (op == OP_MUL);
`else
    assign w_is_mul = 1'b0;
`endif

    // A zero-amount shift is just a pass-through, so it takes the single-cycle path.
    assign w_iter_op    = w_is_mul || ((op == OP_SHIFT) && (w_shamt != '0));
    assign w_iter_start = w_accept & w_iter_op;
    assign w_iter_cnt   = w_is_mul ? CNT_W'(WIDTH) : CNT_W'(w_shamt);

    always_comb begin
        w_simple_res   = W_ONES;
        w_simple_carry = 1'b0;
        case (op)
            OP_XOR:   w_simple_res = input1 ^ input2;
            OP_CMP:   w_simple_res = {{(WIDTH-1){1'b0}}, (input1 != input2)};
            OP_ADD: begin
                w_simple_res   = w_add[WIDTH-1:0];
                w_simple_carry = w_add[WIDTH];
            end
            OP_AND:   w_simple_res = input1 & input2;
            OP_SHIFT: w_simple_res = input1;
            OP_PASS:  w_simple_res = input1;
            OP_SUB: begin
                w_simple_res   = w_sub[WIDTH-1:0];
                w_simple_carry = w_sub[WIDTH];
            end
            OP_OR:    w_simple_res = input1 | input2;
            default:  w_simple_res = W_ONES;
        endcase
    end

    mc_alu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_iter_start),
        .i_left   (w_shift_left),
        .i_count  (w_iter_cnt),
        .i_a      (input1),
`ifdef MC_ALU_MUL_EN
        .i_mul    (w_is_mul),
        .i_b      (input2),
`endif
        .o_done   (w_iter_done),
        .o_result (w_iter_res),
        .o_carry  (w_iter_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_nx = w_iter_op ? EXEC : DONE;
            EXEC:    if (w_iter_done) w_state_nx = DONE;
            DONE:    if (out_ready)   w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (r_state == IDLE);
        out_valid   = (r_state == DONE);
        o_dbg_state = r_state;
    end

    assign w_load       = (w_accept & ~w_iter_op) | ((r_state == EXEC) & w_iter_done);
    assign w_load_res   = (r_state == EXEC) ? w_iter_res   : w_simple_res;
    assign w_load_carry = (r_state == EXEC) ? w_iter_carry : w_simple_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_negative <= 1'b0;
        end else if (w_load) begin
            r_result   <= w_load_res;
            r_zero     <= (w_load_res == '0);
            r_carry    <= w_load_carry;
            r_negative <= w_load_res[WIDTH-1];
        end
    end

    assign result   = r_result;
    assign zero     = r_zero;
    assign carry    = r_carry;
    assign negative = r_negative;

endmodule
